rgb_fade_pwm: RTL

Three-channel PWM LED driver with linear fading. It sits directly downstream of the pattern/colour generators in the dimming designs and drives the RGB LED pins. It accepts target duty values over a valid/ready handshake, ramps each channel's current duty toward its target once per PWM period, and produces glitch-free PWM outputs. All duty changes take effect only at period boundaries.

---
 rtl/rgb_fade_pkg.sv | 23 ++
 rtl/rgb_fade_pwm_channel.sv | 77 +++++++
 rtl/rgb_fade_pwm.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rgb_fade_pkg.sv
// Shared types and helpers for the rgb_fade_pwm LED driver.
// Optional build macro RGB_FADE_GAMMA_EN selects the square-law duty mapping.
package rgb_fade_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;

    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;
    localparam int NUM_CH = 3;

    // Square-law perceptual mapping: (v*v) >> shift, for duty widths up to 16 bits.
    function automatic logic [15:0] gamma_sq(input logic [15:0] v, input int unsigned shift);
        logic [31:0] p;
        p = {16'd0, v} * {16'd0, v};
        p = p >> shift;
        return p[15:0];
    endfunction

endpackage

// File: rtl/rgb_fade_pwm_channel.sv
// One LED channel: current/target duty, saturating fade step, optional gamma and
// the registered PWM compare. Optional build macro: RGB_FADE_GAMMA_EN.
module fade_channel
    import rgb_fade_pkg::*;
#(
    parameter int PWM_W = 8,
    parameter int STEP  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pe,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [PWM_W-1:0] i_pend,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    output logic             o_led,
    output logic [PWM_W-1:0] o_cur,
    output logic [PWM_W-1:0] o_tgt,
    output logic [PWM_W-1:0] o_cur_nxt,
    output logic [PWM_W-1:0] o_tgt_nxt
);

    localparam logic [PWM_W:0] STEP_X = (PWM_W+1)'(STEP);

    logic [PWM_W-1:0] r_cur;
    logic [PWM_W-1:0] r_tgt;
    logic             r_led;
    logic [PWM_W-1:0] w_cur_nxt;
    logic [PWM_W-1:0] w_tgt_nxt;
    logic [PWM_W:0]   w_up;
    logic [PWM_W:0]   w_gap;
    logic [PWM_W-1:0] w_duty;

    // One extra bit keeps the sums and gaps free of wrap so the step saturates at tgt.
    assign w_up  = {1'b0, r_cur} + STEP_X;
    assign w_gap = {1'b0, r_cur} - {1'b0, r_tgt};

    always_comb begin
        w_cur_nxt = r_cur;
        w_tgt_nxt = r_tgt;
        if (i_pe && i_en) begin
            if (r_cur < r_tgt) begin
                w_cur_nxt = (w_up > {1'b0, r_tgt}) ? r_tgt : w_up[PWM_W-1:0];
            end else if (r_cur > r_tgt) begin
                w_cur_nxt = (w_gap > STEP_X) ? (r_cur - STEP_X[PWM_W-1:0]) : r_tgt;
            end
        end
        if (i_pe && i_load) begin
            w_tgt_nxt = i_pend;
        end
    end

`ifdef RGB_FADE_GAMMA_EN
    assign w_duty = PWM_W'(gamma_sq(16'(r_cur), PWM_W));
`else
    assign w_duty = r_cur;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur <= '0;
            r_tgt <= '0;
            r_led <= 1'b0;
        end else begin
            r_cur <= w_cur_nxt;
            r_tgt <= w_tgt_nxt;
            r_led <= (i_pwm_cnt < w_duty);
        end
    end

    assign o_led     = r_led;
    assign o_cur     = r_cur;
    assign o_tgt     = r_tgt;
    assign o_cur_nxt = w_cur_nxt;
    assign o_tgt_nxt = w_tgt_nxt;

endmodule

// File: rtl/rgb_fade_pwm.sv
// Three-channel fading PWM LED driver: prescaler, PWM counter, pending target buffer,
// valid/ready intake and the fade FSM. Optional build macro: RGB_FADE_GAMMA_EN.
module rgb_fade_pwm
    import rgb_fade_pkg::*;
#(
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 4,
    parameter int STEP    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [PWM_W-1:0] i_r,
    input  logic [PWM_W-1:0] i_g,
    input  logic [PWM_W-1:0] i_b,
    output logic             o_led_r,
    output logic             o_led_g,
    output logic             o_led_b,
    output logic             o_busy,
    output fade_state_t      o_state
);

    // Handshake: a triple transfers on any clock edge where i_valid && o_ready.
    // o_ready is a plain register (== !full), so it never depends on i_valid.

    logic [PRESC_W-1:0] r_presc;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic               r_full;
    logic               r_ready;
    logic [PWM_W-1:0]   r_pend [NUM_CH];
    fade_state_t        r_state;
    fade_state_t        w_state_nxt;

    logic               w_tick;
    logic               w_pe;
    logic               w_accept;
    logic               w_full_nxt;
    logic [PWM_W-1:0]   w_in      [NUM_CH];
    logic [PWM_W-1:0]   w_cur     [NUM_CH];
    logic [PWM_W-1:0]   w_tgt     [NUM_CH];
    logic [PWM_W-1:0]   w_cur_nxt [NUM_CH];
    logic [PWM_W-1:0]   w_tgt_nxt [NUM_CH];
    logic [NUM_CH-1:0]  w_led;
    logic [NUM_CH-1:0]  w_eq;
    logic [NUM_CH-1:0]  w_eq_nxt;
    logic               w_any_diff;
    logic               w_all_eq_nxt;

    assign w_tick   = &r_presc;
    assign w_pe     = w_tick && (&r_pwm_cnt);
    assign w_accept = i_valid && r_ready;

    assign w_in[CH_R] = i_r;
    assign w_in[CH_G] = i_g;
    assign w_in[CH_B] = i_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            end
        end
    end

    // The period end drains the buffer; an accept can only occur while it is empty.
    assign w_full_nxt = (w_pe && r_full) ? 1'b0 : (w_accept ? 1'b1 : r_full);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full  <= 1'b0;
            r_ready <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            r_full  <= w_full_nxt;
            r_ready <= !w_full_nxt;
            if (w_accept) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_pend[i] <= w_in[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        fade_channel #(
            .PWM_W (PWM_W),
            .STEP  (STEP)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_pe      (w_pe),
            .i_load    (r_full),
            .i_en      (r_state == FADE),
            .i_pend    (r_pend[gi]),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[gi]),
            .o_cur     (w_cur[gi]),
            .o_tgt     (w_tgt[gi]),
            .o_cur_nxt (w_cur_nxt[gi]),
            .o_tgt_nxt (w_tgt_nxt[gi])
        );

        assign w_eq[gi]     = (w_cur[gi] == w_tgt[gi]);
        assign w_eq_nxt[gi] = (w_cur_nxt[gi] == w_tgt_nxt[gi]);
    end

    assign w_any_diff   = ~&w_eq;
    assign w_all_eq_nxt = &w_eq_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving FADE looks at post-edge values so busy drops right after the settling pe.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (r_full || w_any_diff) w_state_nxt = FADE;
            FADE: if (w_pe && !w_full_nxt && w_all_eq_nxt) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_ready = r_ready;
    assign o_busy  = r_full || (r_state == FADE);
    assign o_state = r_state;
    assign o_led_r = w_led[CH_R];
    assign o_led_g = w_led[CH_G];
    assign o_led_b = w_led[CH_B];

endmodule
